// File: rtl/vga_bus_source_if.sv
// rtl/vga_bus_source_if.sv - VGA pixel bus bundle: advance enable in, packed bus and frame pulse out
interface vga_bus_source_if;
    localparam int VGA_BUS_SIZE = 38;

    logic                    en;
    logic [VGA_BUS_SIZE-1:0] vga_bus_out;
    logic                    frame_start;

    modport master (input en, output vga_bus_out, output frame_start);
    modport slave  (output en, input vga_bus_out, input frame_start);
endinterface

// File: rtl/vga_bus_source.sv
// rtl/vga_bus_source.sv - 800x600@60 VGA timing origin; `VGA_TEST_PATTERN_EN adds 8 colour bars
module vga_bus_source #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic               clk,
    input  logic               rst,
    vga_bus_source_if.master   vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [10:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic        hsync, hblnk, vsync, vblnk;
    logic        hsync_nxt, hblnk_nxt, vsync_nxt, vblnk_nxt;
    logic [11:0] rgb, rgb_nxt;
    logic        frame_start_q, frame_start_nxt;
    logic        line_wrap;

    // Sync/blank derive from the next counts so every field lands on the same edge.
    always_comb begin
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        line_wrap = (h_cnt == 11'(H_TOTAL - 1));
        if (vga.en) begin
            h_nxt = line_wrap ? 11'd0 : h_cnt + 11'd1;
            if (line_wrap)
                v_nxt = (v_cnt == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt + 11'd1;
        end
        hblnk_nxt       = (h_nxt >= 11'(H_ACTIVE));
        vblnk_nxt       = (v_nxt >= 11'(V_ACTIVE));
        hsync_nxt       = (h_nxt >= 11'(HS_START)) && (h_nxt < 11'(HS_END));
        vsync_nxt       = (v_nxt >= 11'(VS_START)) && (v_nxt < 11'(VS_END));
        frame_start_nxt = vga.en && (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [10:0] sub_cnt, sub_nxt;
    logic [2:0]  bar_cnt, bar_nxt;

    // Bar index tracks hcount / BAR_W incrementally; it is reset on every line wrap.
    always_comb begin
        sub_nxt = sub_cnt;
        bar_nxt = bar_cnt;
        if (vga.en) begin
            if (line_wrap) begin
                sub_nxt = 11'd0;
                bar_nxt = 3'd0;
            end else if (sub_cnt == 11'(BAR_W - 1)) begin
                sub_nxt = 11'd0;
                bar_nxt = bar_cnt + 3'd1;
            end else begin
                sub_nxt = sub_cnt + 11'd1;
            end
        end
        rgb_nxt = (hblnk_nxt || vblnk_nxt) ? 12'h000
                : {{4{bar_nxt[2]}}, {4{bar_nxt[1]}}, {4{bar_nxt[0]}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_cnt <= '0;
            bar_cnt <= '0;
        end else begin
            sub_cnt <= sub_nxt;
            bar_cnt <= bar_nxt;
        end
    end
`else
    assign rgb_nxt = 12'h000;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync         <= 1'b0;
            hblnk         <= 1'b0;
            vsync         <= 1'b0;
            vblnk         <= 1'b0;
            rgb           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            hsync         <= hsync_nxt;
            hblnk         <= hblnk_nxt;
            vsync         <= vsync_nxt;
            vblnk         <= vblnk_nxt;
            rgb           <= rgb_nxt;
            frame_start_q <= frame_start_nxt;
        end
    end

    assign vga.vga_bus_out = {h_cnt, hsync, hblnk, v_cnt, vsync, vblnk, rgb};
    assign vga.frame_start = frame_start_q;
endmodule
